// File: rtl/hfrv_tap_pkg.sv
// Shared constants and types for the hfrv console tap: register offsets and
// the arbiter state encoding.
package hfrv_tap_pkg;

  localparam int unsigned CH_STRIDE = 4;
  localparam logic [31:0] CTRL_OFS  = 32'h0000_0100;
  localparam logic [31:0] EXIT_OFS  = 32'h0000_0104;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Word-granular address compare; byte-lane bits are ignored.
  function automatic logic word_match(input logic [31:0] addr, input logic [31:0] ref_addr);
    return addr[31:2] == ref_addr[31:2];
  endfunction

endpackage

// File: rtl/hfrv_tap_fifo.sv
// First-word-fall-through byte FIFO for one console channel. A push into a full
// FIFO is accepted when a pop happens in the same cycle.
module hfrv_tap_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic       last
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic [AW:0] used_s;
  logic [7:0]  mem_r [DEPTH];
  logic        wr_en_s;
  logic        rd_en_s;

  // Status flags, enables and the fall-through head byte.
  always_comb begin
    empty   = (wr_ptr_r == rd_ptr_r);
    full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    used_s  = wr_ptr_r - rd_ptr_r;
    last    = (used_s == (AW+1)'(1));
    rd_en_s = pop & ~empty;
    wr_en_s = push & (~full | rd_en_s);
    dout    = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Read and write pointers, wrapping naturally with an extra lap bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/hfrv_console_tap.sv
// Snoops CPU data-bus writes into per-channel console FIFOs, drains them as one
// channel-tagged byte stream under a round-robin arbiter, and latches an exit code.
module hfrv_console_tap
  import hfrv_tap_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'hF000_0000,
  parameter logic [31:0] CTRL_ADDR = BASE_ADDR + CTRL_OFS,
  parameter logic [31:0] EXIT_ADDR = BASE_ADDR + EXIT_OFS,
  localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bus_valid,
  input  logic [31:0]     bus_addr,
  input  logic [31:0]     bus_wdata,
  input  logic [3:0]      bus_wstrb,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH_W-1:0] out_ch,
  output logic [7:0]      out_data,
  output logic [N_CH-1:0] ovf,
  output logic            exit_valid,
  output logic [31:0]     exit_code
);

  logic            wr_s;
  logic [31:0]     ch_ofs_s;
  logic            ch_hit_s;
  logic [CH_W-1:0] ch_sel_s;
  logic            ctrl_clr_s;
  logic            exit_hit_s;
  logic            xfer_s;

  logic [N_CH-1:0] push_s;
  logic [N_CH-1:0] pop_s;
  logic [N_CH-1:0] full_s;
  logic [N_CH-1:0] empty_s;
  logic [N_CH-1:0] last_s;
  logic [N_CH-1:0] ovf_set_s;
  logic [N_CH-1:0] nonempty_nxt_s;
  logic [7:0]      dout_s [N_CH];

  arb_state_t      state_r;
  arb_state_t      state_nxt_s;
  logic [CH_W-1:0] locked_r;
  logic [CH_W-1:0] locked_nxt_s;
  logic [CH_W-1:0] rr_ptr_r;
  logic [CH_W-1:0] rr_ptr_nxt_s;
  logic [CH_W-1:0] base_s;
  logic [CH_W-1:0] pick_s;
  logic [CH_W:0]   sum_s;
  logic            found_s;

  logic [N_CH-1:0] ovf_r;
  logic            exit_valid_r;
  logic [31:0]     exit_code_r;

  // Bus decode and per-channel push/pop/overflow qualification.
  always_comb begin
    wr_s       = bus_valid & (|bus_wstrb);
    ch_ofs_s   = {bus_addr[31:2], 2'b00} - {BASE_ADDR[31:2], 2'b00};
    ch_hit_s   = wr_s && (ch_ofs_s < 32'(N_CH * CH_STRIDE));
    ch_sel_s   = ch_ofs_s[CH_W+1:2];
    ctrl_clr_s = wr_s && word_match(bus_addr, CTRL_ADDR) && bus_wdata[0];
    exit_hit_s = wr_s && word_match(bus_addr, EXIT_ADDR);
    xfer_s     = (state_r == ARB_GRANT) && out_ready;
    for (int i = 0; i < N_CH; i++) begin
      push_s[i]    = ch_hit_s && (ch_sel_s == CH_W'(i));
      pop_s[i]     = xfer_s && (locked_r == CH_W'(i));
      ovf_set_s[i] = push_s[i] & full_s[i] & ~pop_s[i];
      // Occupancy after this edge, so a fresh push can be granted immediately.
      nonempty_nxt_s[i] = (push_s[i] & (~full_s[i] | pop_s[i]))
                        | (~empty_s[i] & ~(pop_s[i] & last_s[i]));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_fifo
    hfrv_tap_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s[g]),
      .din   (bus_wdata[7:0]),
      .pop   (pop_s[g]),
      .dout  (dout_s[g]),
      .full  (full_s[g]),
      .empty (empty_s[g]),
      .last  (last_s[g])
    );
  end

  // Sticky overflow flags and the write-once exit code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r        <= {N_CH{1'b0}};
      exit_valid_r <= 1'b0;
      exit_code_r  <= 32'h0000_0000;
    end else begin
      ovf_r <= (ctrl_clr_s ? {N_CH{1'b0}} : ovf_r) | ovf_set_s;
      if (exit_hit_s && !exit_valid_r) begin
        exit_valid_r <= 1'b1;
        exit_code_r  <= bus_wdata;
      end
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ARB_IDLE;
      locked_r <= {CH_W{1'b0}};
      rr_ptr_r <= {CH_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      locked_r <= locked_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
    end
  end

  // Arbiter next state: round-robin search over post-edge occupancy.
  always_comb begin
    state_nxt_s  = state_r;
    locked_nxt_s = locked_r;
    rr_ptr_nxt_s = rr_ptr_r;
    if (xfer_s) begin
      rr_ptr_nxt_s = (locked_r == CH_W'(N_CH - 1)) ? {CH_W{1'b0}} : locked_r + CH_W'(1);
    end else begin
      rr_ptr_nxt_s = rr_ptr_r;
    end
    base_s  = rr_ptr_nxt_s;
    found_s = 1'b0;
    pick_s  = {CH_W{1'b0}};
    sum_s   = {(CH_W+1){1'b0}};
    for (int k = 0; k < N_CH; k++) begin
      sum_s = {1'b0, base_s} + (CH_W+1)'(k);
      if (sum_s >= (CH_W+1)'(N_CH)) begin
        sum_s = sum_s - (CH_W+1)'(N_CH);
      end else begin
        sum_s = sum_s;
      end
      if (!found_s && nonempty_nxt_s[sum_s[CH_W-1:0]]) begin
        found_s = 1'b1;
        pick_s  = sum_s[CH_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
    case (state_r)
      ARB_IDLE: begin
        if (found_s) begin
          state_nxt_s  = ARB_GRANT;
          locked_nxt_s = pick_s;
        end else begin
          state_nxt_s  = ARB_IDLE;
        end
      end
      ARB_GRANT: begin
        if (xfer_s && found_s) begin
          locked_nxt_s = pick_s;
        end else if (xfer_s) begin
          state_nxt_s  = ARB_IDLE;
        end else begin
          state_nxt_s  = ARB_GRANT;
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
      end
    endcase
  end

  // Output decode: the locked FIFO head is presented only while granted.
  always_comb begin
    out_valid  = (state_r == ARB_GRANT);
    out_ch     = locked_r;
    if (state_r == ARB_GRANT) begin
      out_data = dout_s[locked_r];
    end else begin
      out_data = 8'h00;
    end
    ovf        = ovf_r;
    exit_valid = exit_valid_r;
    exit_code  = exit_code_r;
  end

endmodule
